// File: rtl/exm_pkg.sv
// Shared encodings for the multi-cycle execute/memory stage: ALU opcodes,
// operand forward selects and the stage FSM states.
package exm_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_NOT  = 3'b100,
    ALU_INC  = 3'b101,
    ALU_DEC  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_RES = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {ST_IDLE, ST_MEM} state_e;
endpackage

// File: rtl/exm_alu.sv
// Combinational ALU; c_valid marks ops that produce a carry/borrow.
module exm_alu
  import exm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              c_valid
);
  logic [DATA_W:0] ext;
  logic [DATA_W:0] one;

  assign one = {{DATA_W{1'b0}}, 1'b1};

  // Subtractions wrap through the extra top bit, which is then the borrow.
  always_comb begin
    ext     = '0;
    c_valid = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD:  begin ext = {1'b0, a} + {1'b0, b}; c_valid = 1'b1; end
      ALU_SUB:  begin ext = {1'b0, a} - {1'b0, b}; c_valid = 1'b1; end
      ALU_AND:  ext = {1'b0, a & b};
      ALU_OR:   ext = {1'b0, a | b};
      ALU_NOT:  ext = {1'b0, ~a};
      ALU_INC:  begin ext = {1'b0, a} + one; c_valid = 1'b1; end
      ALU_DEC:  begin ext = {1'b0, a} - one; c_valid = 1'b1; end
      ALU_PASS: ext = {1'b0, b};
      default:  ext = '0;
    endcase
  end

  assign result = ext[DATA_W-1:0];
  assign c      = ext[DATA_W];
  assign z      = (result == '0);
  assign n      = result[DATA_W-1];
endmodule

// File: rtl/exm_stage_mc.sv
// Multi-cycle execute/memory stage: forwarded ALU, flags, stack pointer and a
// ready-handshaked data-memory port that stalls upstream while busy.
module exm_stage_mc
  import exm_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter int                REG_W   = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [2:0]        i_alu_function,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_immediate,
  input  logic              i_imm,
  input  logic [1:0]        i_fwd1_sel,
  input  logic [1:0]        i_fwd2_sel,
  input  logic [DATA_W-1:0] i_data_wb,
  input  logic              i_flag_en,
  input  logic              i_change_carry,
  input  logic              i_carry_value,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_stack_operation,
  input  logic              i_stack_function,
  input  logic              i_write_back,
  input  logic [1:0]        i_wb_selector,
  input  logic [REG_W-1:0]  i_write_addr,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_write_back,
  output logic [1:0]        o_wb_selector,
  output logic [REG_W-1:0]  o_write_addr,
  output logic              o_zero_flag,
  output logic              o_negative_flag,
  output logic              o_carry_flag,
  output logic [ADDR_W-1:0] o_sp
);
  localparam int STAGES = 1;

  state_e            state;
  logic [STAGES:0]   vld_pipe;
  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic              alu_z, alu_n, alu_c, alu_cv;
  logic              accept, mem_op, pop, we_nxt, c_nxt;
  logic [ADDR_W-1:0] sp_inc, sp_dec, addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  always_comb begin
    case (i_fwd1_sel)
      FWD_RES: op_a = o_result;
      FWD_WB:  op_a = i_data_wb;
      default: op_a = i_data1;
    endcase
    case (i_fwd2_sel)
      FWD_RES: op_b = o_result;
      FWD_WB:  op_b = i_data_wb;
      default: op_b = i_data2;
    endcase
    if (i_imm) op_b = i_immediate;
  end

  exm_alu #(.DATA_W(DATA_W)) u_alu (
    .op(i_alu_function), .a(op_a), .b(op_b),
    .result(alu_res), .z(alu_z), .n(alu_n), .c(alu_c), .c_valid(alu_cv)
  );

  assign accept = i_valid && (state == ST_IDLE);
  assign mem_op = i_mem_read | i_mem_write | i_stack_operation;
  assign pop    = i_stack_operation & i_stack_function;
  assign sp_inc = o_sp + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign sp_dec = o_sp - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign we_nxt = i_stack_operation ? ~i_stack_function : i_mem_write;

  // Push writes at SP then decrements; pop increments then reads the new SP.
  assign addr_nxt  = i_stack_operation ? (pop ? sp_inc : o_sp)
                   : (i_mem_write ? ADDR_W'(i_data1) : ADDR_W'(i_data2));
  assign wdata_nxt = i_stack_operation ? op_a : i_data2;
  assign c_nxt     = i_change_carry ? i_carry_value
                   : ((i_flag_en && alu_cv) ? alu_c : o_carry_flag);

  assign vld_pipe[0] = (accept && !mem_op) || ((state == ST_MEM) && i_mem_ready);
  assign o_valid     = vld_pipe[STAGES];
  assign o_stall     = (state == ST_MEM);
  assign o_mem_req   = (state == ST_MEM);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                <= ST_IDLE;
      vld_pipe[STAGES:1]   <= '0;
      o_result             <= '0;
      o_mem_data           <= '0;
      o_mem_we             <= 1'b0;
      o_mem_addr           <= '0;
      o_mem_wdata          <= '0;
      o_write_back         <= 1'b0;
      o_wb_selector        <= '0;
      o_write_addr         <= '0;
      o_zero_flag          <= 1'b0;
      o_negative_flag      <= 1'b0;
      o_carry_flag         <= 1'b0;
      o_sp                 <= SP_INIT;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      case (state)
        ST_IDLE: if (accept) begin
          o_result      <= alu_res;
          o_write_back  <= i_write_back;
          o_wb_selector <= i_wb_selector;
          o_write_addr  <= i_write_addr;
          o_carry_flag  <= c_nxt;
          if (i_flag_en) begin
            o_zero_flag     <= alu_z;
            o_negative_flag <= alu_n;
          end
          if (mem_op) begin
            o_mem_addr  <= addr_nxt;
            o_mem_wdata <= wdata_nxt;
            o_mem_we    <= we_nxt;
            state       <= ST_MEM;
            if (i_stack_operation) o_sp <= pop ? sp_inc : sp_dec;
          end
        end
        ST_MEM: if (i_mem_ready) begin
          if (!o_mem_we) o_mem_data <= i_mem_rdata;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
